fifo_bank: RTL and testbench

- Parametrised multi-channel FIFO bank that replaces individually instantiated input FIFOs feeding the MAC array.
- Provides NUM_CH independent FIFOs with per-channel push/pop, fill-level counts, almost-full flags and sticky overflow/underflow error flags.
- Adds a lockstep pop (rd_all) that pops every channel in the same cycle, but only when all channels hold data. This lets the MAC array consume one aligned vector per cycle.

---
 rtl/fifo_bank_if.sv | 33 +++
 rtl/fifo_bank.sv | 113 +++++++++++
 tb/tb_fifo_bank.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_bank_if.sv
// rtl/fifo_bank_if.sv - push/pop, status and error bundle for the multi-channel FIFO bank
interface fifo_bank_if #(
  parameter int NUM_CH     = 8,
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [NUM_CH-1:0]            wren;
  logic [NUM_CH-1:0]            rden;
  logic                         rd_all;
  logic                         clr_err;
  logic [NUM_CH*DATA_WIDTH-1:0] i_data;
  logic [NUM_CH*DATA_WIDTH-1:0] o_data;
  logic [NUM_CH-1:0]            o_valid;
  logic [NUM_CH-1:0]            full;
  logic [NUM_CH-1:0]            empty;
  logic [NUM_CH-1:0]            almost_full;
  logic [NUM_CH*CNT_W-1:0]      count;
  logic                         all_ready;
  logic [NUM_CH-1:0]            overflow;
  logic [NUM_CH-1:0]            underflow;

  modport master (
    output wren, rden, rd_all, clr_err, i_data,
    input  o_data, o_valid, full, empty, almost_full, count, all_ready, overflow, underflow
  );

  modport slave (
    input  wren, rden, rd_all, clr_err, i_data,
    output o_data, o_valid, full, empty, almost_full, count, all_ready, overflow, underflow
  );
endinterface

// File: rtl/fifo_bank.sv
// rtl/fifo_bank.sv - NUM_CH independent FIFOs with lockstep pop for the MAC array inputs
module fifo_bank #(
  parameter int NUM_CH     = 8,
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8,
  parameter int AF_THRESH  = DEPTH - 1
) (
  input  logic         clk,
  input  logic         rst,
  fifo_bank_if.slave   bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);

  logic [NUM_CH-1:0]     empty_v;
  logic [NUM_CH-1:0]     full_v;
  logic [NUM_CH-1:0]     af_v;
  logic [NUM_CH-1:0]     valid_v;
  logic [NUM_CH-1:0]     ovf_v;
  logic [NUM_CH-1:0]     unf_v;
  logic [DATA_WIDTH-1:0] dout_a [NUM_CH];
  logic [CNT_W-1:0]      cnt_a  [NUM_CH];
  logic                  all_ready;
  logic                  lock_fire;

  // Lockstep pop only fires when every channel can supply a word this cycle.
  assign all_ready = &(~empty_v);
  assign lock_fire = bus.rd_all & all_ready;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] dout;
    logic [DATA_WIDTH-1:0] din;
    logic                  ovalid;
    logic                  ovf;
    logic                  unf;
    logic                  pop_req;
    logic                  pop_ok;
    logic                  push_ok;

    assign din        = bus.i_data[i*DATA_WIDTH +: DATA_WIDTH];
    assign empty_v[i] = (cnt == '0);
    assign full_v[i]  = (cnt == DEPTH_C);
    assign af_v[i]    = (cnt >= AF_C);
    assign pop_req    = bus.rden[i] | lock_fire;
    assign pop_ok     = pop_req & ~empty_v[i];
    // A pop in the same cycle frees the slot, so a full channel still accepts the push.
    assign push_ok    = bus.wren[i] & (~full_v[i] | pop_ok);

    always_ff @(posedge clk) begin
      if (!rst && push_ok) begin
        mem[wr_ptr] <= din;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
        dout   <= '0;
        ovalid <= 1'b0;
        ovf    <= 1'b0;
        unf    <= 1'b0;
      end else begin
        ovalid <= pop_ok;
        if (push_ok) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop_ok) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
          dout   <= mem[rd_ptr];
        end
        case ({push_ok, pop_ok})
          2'b10:   cnt <= cnt + CNT_W'(1);
          2'b01:   cnt <= cnt - CNT_W'(1);
          default: cnt <= cnt;
        endcase
        // Set has priority over clr_err.
        ovf <= (ovf & ~bus.clr_err) | (bus.wren[i] & full_v[i] & ~pop_ok);
        unf <= (unf & ~bus.clr_err) | (pop_req & empty_v[i]);
      end
    end

    assign dout_a[i]  = dout;
    assign cnt_a[i]   = cnt;
    assign valid_v[i] = ovalid;
    assign ovf_v[i]   = ovf;
    assign unf_v[i]   = unf;
  end

  always_comb begin
    bus.o_data = '0;
    bus.count  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      bus.o_data[c*DATA_WIDTH +: DATA_WIDTH] = dout_a[c];
      bus.count[c*CNT_W +: CNT_W]            = cnt_a[c];
    end
  end

  assign bus.o_valid     = valid_v;
  assign bus.full        = full_v;
  assign bus.empty       = empty_v;
  assign bus.almost_full = af_v;
  assign bus.all_ready   = all_ready;
  assign bus.overflow    = ovf_v;
  assign bus.underflow   = unf_v;
endmodule

// File: tb/tb_fifo_bank.sv
// tb/tb_fifo_bank.sv - scoreboard bench for fifo_bank with directed vectors
module tb_fifo_bank;
  logic clk;
  logic rst;

  fifo_bank_if #(.NUM_CH(8), .DEPTH(8), .DATA_WIDTH(8)) bus ();

  fifo_bank #(.NUM_CH(8), .DEPTH(8), .DATA_WIDTH(8), .AF_THRESH(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [2:0] ch;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   tests;
  int   fails;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pop(input int ch, input logic [7:0] d);
    exp_t e;
    e.ch   = 3'(ch);
    e.data = d;
    exp_q.push_back(e);
  endtask

  function automatic logic [3:0] cnt_of(input int ch);
    return bus.count[ch*4 +: 4];
  endfunction

  // Monitor: every o_valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    for (int c = 0; c < 8; c++) begin
      if (bus.o_valid[c]) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_pop: ch%0d data %h with no expectation", c, bus.o_data[c*8 +: 8]);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.ch != 3'(c) || e.data != bus.o_data[c*8 +: 8]) begin
            fails++;
            $display("FAIL pop_data: got ch%0d %h expected ch%0d %h", c, bus.o_data[c*8 +: 8], e.ch, e.data);
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] mq[$];
    int mcnt;
    logic wr;
    logic rd;
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.wren = '0;
    bus.rden = '0;
    bus.rd_all = 1'b0;
    bus.clr_err = 1'b0;
    bus.i_data = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    check("rst_empty", 64'(bus.empty), 64'hFF);
    check("rst_count", 64'(bus.count), 64'h0);
    check("rst_all_ready", 64'(bus.all_ready), 64'h0);
    check("rst_full", 64'(bus.full), 64'h0);
    check("rst_af", 64'(bus.almost_full), 64'h0);
    check("rst_ovf_unf", {48'h0, bus.overflow, bus.underflow}, 64'h0);
    check("rst_ovalid", 64'(bus.o_valid), 64'h0);
    check("rst_odata", bus.o_data, 64'h0);

    // Fill ch0 and drain in order
    for (int k = 0; k < 8; k++) begin
      bus.wren = 8'h01;
      bus.i_data = 64'(8'h11 + 8'(k));
      tick();
      if (k == 5) check("ch0_af_at6", 64'(bus.almost_full[0]), 64'h0);
      if (k == 6) check("ch0_af_at7", 64'(bus.almost_full[0]), 64'h1);
    end
    bus.wren = '0;
    check("ch0_full", 64'(bus.full[0]), 64'h1);
    check("ch0_count8", 64'(cnt_of(0)), 64'h8);
    for (int k = 0; k < 8; k++) begin
      bus.rden = 8'h01;
      expect_pop(0, 8'h11 + 8'(k));
      tick();
    end
    bus.rden = '0;
    tick();
    check("ch0_empty", 64'(bus.empty[0]), 64'h1);
    check("ch0_valid_drop", 64'(bus.o_valid), 64'h0);
    check("ch0_hold", 64'(bus.o_data[7:0]), 64'h18);

    // Overflow on ch3
    for (int k = 0; k < 8; k++) begin
      bus.wren = 8'h08;
      bus.i_data = 64'(8'h30 + 8'(k)) << 24;
      tick();
    end
    bus.i_data = 64'hAA << 24;
    tick();
    check("ch3_ovf", 64'(bus.overflow), 64'h08);
    check("ch3_cnt_ovf", 64'(cnt_of(3)), 64'h8);
    bus.rden = 8'h08;
    bus.i_data = 64'hBB << 24;
    expect_pop(3, 8'h30);
    tick();
    bus.wren = '0;
    bus.rden = '0;
    check("ch3_cnt_pushpop", 64'(cnt_of(3)), 64'h8);
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    check("ch3_clr", 64'(bus.overflow), 64'h0);
    for (int k = 0; k < 8; k++) begin
      bus.rden = 8'h08;
      expect_pop(3, (k == 7) ? 8'hBB : 8'h31 + 8'(k));
      tick();
    end
    bus.rden = '0;
    tick();
    check("ch3_empty", 64'(bus.empty[3]), 64'h1);

    // Lockstep pop blocked until every channel has data
    bus.wren = 8'h7F;
    bus.i_data = 64'h0006050403020100;
    tick();
    bus.wren = '0;
    bus.rd_all = 1'b1;
    tick();
    bus.rd_all = 1'b0;
    check("lock_blocked_valid", 64'(bus.o_valid), 64'h0);
    check("lock_blocked_unf", 64'(bus.underflow), 64'h0);
    check("lock_blocked_cnt0", 64'(cnt_of(0)), 64'h1);
    bus.wren = 8'h80;
    bus.i_data = 64'h0700000000000000;
    tick();
    bus.wren = '0;
    check("all_ready", 64'(bus.all_ready), 64'h1);
    bus.rd_all = 1'b1;
    for (int c = 0; c < 8; c++) expect_pop(c, 8'(c));
    tick();
    bus.rd_all = 1'b0;
    check("lock_valid", 64'(bus.o_valid), 64'hFF);
    check("lock_data", bus.o_data, 64'h0706050403020100);
    check("lock_empty", 64'(bus.empty), 64'hFF);

    // Interleaved push/pop on ch1 across pointer wrap
    mcnt = 0;
    mq.delete();
    bus.wren = 8'h02;
    bus.i_data = 64'h3F << 8;
    mq.push_back(8'h3F);
    mcnt = 1;
    tick();
    for (int k = 0; k < 20; k++) begin
      rd = (k % 3 != 0) && (mcnt > 1);
      wr = (k % 4 != 3) && ((mcnt < 8) || rd);
      bus.wren = {6'b0, wr, 1'b0};
      bus.rden = {6'b0, rd, 1'b0};
      bus.i_data = 64'(8'h40 + 8'(k)) << 8;
      if (rd) expect_pop(1, mq.pop_front());
      if (wr) mq.push_back(8'h40 + 8'(k));
      mcnt = mcnt + int'(wr) - int'(rd);
      tick();
    end
    bus.wren = '0;
    check("ch1_wrap_cnt", 64'(cnt_of(1)), 64'(mcnt));
    while (mq.size() > 0) begin
      bus.rden = 8'h02;
      expect_pop(1, mq.pop_front());
      tick();
    end
    bus.rden = 8'h02;
    bus.wren = 8'h02;
    bus.i_data = 64'h5A << 8;
    tick();
    bus.wren = '0;
    bus.rden = '0;
    check("ch1_unf", 64'(bus.underflow[1]), 64'h1);
    check("ch1_cnt1", 64'(cnt_of(1)), 64'h1);
    check("ch1_nobypass", 64'(bus.o_valid[1]), 64'h0);
    bus.rden = 8'h02;
    expect_pop(1, 8'h5A);
    tick();
    bus.rden = '0;
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;

    // Reset mid-operation on ch2
    for (int k = 0; k < 5; k++) begin
      bus.wren = 8'h04;
      bus.i_data = 64'(8'h21 + 8'(k)) << 16;
      tick();
    end
    bus.wren = '0;
    check("ch2_cnt5", 64'(cnt_of(2)), 64'h5);
    bus.rden = 8'h04;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.rden = '0;
    check("mid_rst_cnt", 64'(bus.count), 64'h0);
    check("mid_rst_valid", 64'(bus.o_valid), 64'h0);
    check("mid_rst_data", bus.o_data, 64'h0);
    bus.rden = 8'h04;
    tick();
    bus.rden = '0;
    check("post_rst_unf", 64'(bus.underflow), 64'h04);
    check("post_rst_novalid", 64'(bus.o_valid), 64'h0);
    tick();
    tick();
    check("scoreboard_drained", 64'(exp_q.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
